// File: rtl/led_ctrl_pkg.sv
// Shared types and LED encodings for the CPU self-test LED sequencer.
package led_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TOUT = 3'd4
  } state_t;

  localparam logic [7:0] LED_IDLE = 8'h01;
  localparam logic [7:0] LED_PASS = 8'h07;

  localparam int LED_RUN_BIT   = 7;
  localparam int LED_FAULT_MSB = 7;
  localparam int LED_TOUT_BIT  = 3;

endpackage

// File: rtl/blink_div.sv
// Free-running prescaler producing a square wave with a BLINK_DIV-cycle half-period.
module blink_div #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic blink
);

  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      blink <= ~blink;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/selftest_led_ctrl.sv
// Self-test session sequencer: captures check flags, watches for timeout and
// shows the outcome on the user LEDs.
module selftest_led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int BLINK_DIV      = 25_000_000,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       check_one,
  input  logic       check_two,
  input  logic       fail,
  input  logic       done,
  output logic [7:0] led,
  output logic [2:0] state_o,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t        state, state_nxt;
  logic          s1, s2, s1_nxt, s2_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          blink;
  logic          e1, e2;
  logic [7:0]    led_nxt;

  blink_div #(.BLINK_DIV(BLINK_DIV)) u_blink_div (
    .clk  (clk),
    .rst  (rst),
    .blink(blink)
  );

  assign e1 = s1 | check_one;
  assign e2 = s2 | check_two;

  // Leaving RUN latches the effective flags so the final LED code includes that cycle's checks.
  always_comb begin
    state_nxt = state;
    s1_nxt    = s1;
    s2_nxt    = s2;
    timer_nxt = timer;
    if (state == ST_RUN) begin
      if (start) begin
        s1_nxt    = 1'b0;
        s2_nxt    = 1'b0;
        timer_nxt = '0;
      end else begin
        s1_nxt = e1;
        s2_nxt = e2;
        if (fail)
          state_nxt = ST_FAIL;
        else if (done)
          state_nxt = (e1 & e2) ? ST_PASS : ST_FAIL;
        else if (timer == TW'(TIMEOUT_CYCLES - 1))
          state_nxt = ST_TOUT;
        else
          timer_nxt = timer + 1'b1;
      end
    end else if (start) begin
      state_nxt = ST_RUN;
      s1_nxt    = 1'b0;
      s2_nxt    = 1'b0;
      timer_nxt = '0;
    end
  end

  always_comb begin
    led_nxt = {5'b0, s2_nxt, s1_nxt, 1'b1};
    case (state_nxt)
      ST_IDLE: led_nxt = LED_IDLE;
      ST_RUN:  led_nxt[LED_RUN_BIT] = blink;
      ST_PASS: led_nxt = LED_PASS;
      ST_FAIL: led_nxt[LED_FAULT_MSB -: 4] = {4{blink}};
      ST_TOUT: begin
        led_nxt[LED_FAULT_MSB -: 4] = {4{blink}};
        led_nxt[LED_TOUT_BIT]       = 1'b1;
      end
      default: led_nxt = LED_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      s1    <= 1'b0;
      s2    <= 1'b0;
      timer <= '0;
      led   <= 8'h00;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      s1    <= s1_nxt;
      s2    <= s2_nxt;
      timer <= timer_nxt;
      led   <= led_nxt;
      busy  <= (state_nxt == ST_RUN);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_selftest_led_ctrl.sv
// Directed bench for selftest_led_ctrl with BLINK_DIV=4, TIMEOUT_CYCLES=16.
module tb_selftest_led_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       check_one = 1'b0;
  logic       check_two = 1'b0;
  logic       fail = 1'b0;
  logic       done = 1'b0;
  logic [7:0] led;
  logic [2:0] state_o;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  selftest_led_ctrl #(.BLINK_DIV(4), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .check_one(check_one),
    .check_two(check_two),
    .fail     (fail),
    .done     (done),
    .led      (led),
    .state_o  (state_o),
    .busy     (busy)
  );

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", tag, got, exp, $time);
    else
      passes++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic s, input logic c1, input logic c2,
                               input logic f, input logic d);
    start = s; check_one = c1; check_two = c2; fail = f; done = d;
    tick();
    start = 0; check_one = 0; check_two = 0; fail = 0; done = 0;
  endtask

  // LED at edge n shows the blink value held after n-1 prescaler edges.
  function automatic logic [7:0] fault_mask(input int n);
    return ((((n - 1) / 4) % 2) != 0) ? 8'hF0 : 8'h00;
  endfunction

  function automatic logic [7:0] run_mask(input int n);
    return fault_mask(n) & 8'h80;
  endfunction

  initial begin
    tick(); tick();
    checkOutput("rst_led", led, 8'h00);
    checkOutput("rst_state", {5'b0, state_o}, 8'h00);
    checkOutput("rst_busy", {7'b0, busy}, 8'h00);
    rst = 1'b1;
    cyc = 0;
    tick();
    checkOutput("idle_led", led, 8'h01);
    checkOutput("idle_state", {5'b0, state_o}, 8'h00);
    checkOutput("idle_busy", {7'b0, busy}, 8'h00);

    $display("[TB] pass session");
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("run_state", {5'b0, state_o}, 8'h01);
    checkOutput("run_busy", {7'b0, busy}, 8'h01);
    checkOutput("run_led", led, run_mask(cyc) | 8'h01);
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(0, c == 3, c == 5, 0, c == 8);
      if (c == 4) checkOutput("run_led_s1", led, run_mask(cyc) | 8'h03);
      if (c == 7) checkOutput("run_led_s12", led, run_mask(cyc) | 8'h07);
    end
    checkOutput("pass_state", {5'b0, state_o}, 8'h02);
    checkOutput("pass_led", led, 8'h07);
    checkOutput("pass_busy", {7'b0, busy}, 8'h00);
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pass_hold_led", led, 8'h07);
    checkOutput("pass_hold_state", {5'b0, state_o}, 8'h02);

    $display("[TB] fail session");
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 1; c <= 6; c++) applyStimulus(0, 1, 0, 0, c == 6);
    checkOutput("fail_state", {5'b0, state_o}, 8'h03);
    checkOutput("fail_busy", {7'b0, busy}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      checkOutput("fail_led", led, fault_mask(cyc) | 8'h03);
      applyStimulus(0, 0, 0, 0, 0);
    end

    $display("[TB] timeout session");
    applyStimulus(1, 0, 0, 0, 0);
    for (int c = 1; c <= 15; c++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tout_edge15_state", {5'b0, state_o}, 8'h01);
    checkOutput("tout_edge15_busy", {7'b0, busy}, 8'h01);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("tout_state", {5'b0, state_o}, 8'h04);
    checkOutput("tout_busy", {7'b0, busy}, 8'h00);
    for (int k = 0; k < 8; k++) begin
      checkOutput("tout_led", led, fault_mask(cyc) | 8'h09);
      applyStimulus(0, 0, 0, 0, 0);
    end

    $display("[TB] fail and done together");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 0, 0, 1, 1);
    checkOutput("faildone_state", {5'b0, state_o}, 8'h03);
    checkOutput("faildone_led", led, fault_mask(cyc) | 8'h07);

    $display("[TB] restart beats fail");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("restart_state", {5'b0, state_o}, 8'h01);
    checkOutput("restart_busy", {7'b0, busy}, 8'h01);
    for (int c = 1; c <= 15; c++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart_timer_state", {5'b0, state_o}, 8'h01);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("restart_tout_state", {5'b0, state_o}, 8'h04);

    $display("[TB] reset mid-run");
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("midrun_s1", {7'b0, led[1]}, 8'h01);
    rst = 1'b0;
    #1;
    checkOutput("async_rst_led", led, 8'h00);
    checkOutput("async_rst_state", {5'b0, state_o}, 8'h00);
    checkOutput("async_rst_busy", {7'b0, busy}, 8'h00);
    tick(); tick();
    rst = 1'b1;
    cyc = 0;
    tick();
    checkOutput("rerelease_led", led, 8'h01);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("rerun_state", {5'b0, state_o}, 8'h01);
    checkOutput("rerun_sticky", led & 8'h7F, 8'h01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
